c2_serialize: RTL and testbench

- Converts parallel CH-lane conv2 feature words back into a channel-interleaved serial stream.
- Input: one CH×DATA_W word per transfer, lane k = channel k. Output: one DATA_W sample per beat, order ch0, ch1, …, ch(CH-1), then the next word.
- Sits between the conv2 parallel datapath and serial-input consumers (pooling/flatten, debug capture).
- Frame = FRAME_LEN input words = FRAME_LEN×CH output beats. Defaults: 121 words, 363 beats.

---
 rtl/c2_pkg.sv | 23 ++
 rtl/c2_ser_fifo.sv | 55 +++++
 rtl/c2_serialize.sv | 148 ++++++++++++++
 tb/tb_c2_serialize.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c2_pkg.sv
// c2_pkg: shared constants, FSM state type and lane-slice helper for the conv2 serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c2_pkg;

  localparam int C2_DATA_W    = 16;
  localparam int C2_CH        = 3;
  localparam int C2_FRAME_LEN = 121;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } c2_state_e;

  // Lane k of a default-geometry conv2 word (lane k = channel k).
  function automatic logic [C2_DATA_W-1:0] get_lane(
    input logic [C2_CH*C2_DATA_W-1:0] word,
    input int unsigned                k
  );
    return word[k*C2_DATA_W +: C2_DATA_W];
  endfunction

endpackage

// File: rtl/c2_ser_fifo.sv
// c2_ser_fifo: generic synchronous FIFO, DEPTH words of WIDTH bits, read data registered on rd_en.
// Latency: a word written at edge N can be popped at edge N+1; dout updates on the popping edge.
// Backpressure: writes while full and reads while empty are ignored; full/empty come from pointers.
// Ports: clk, rst_n (async, active-high), wr_en/din, rd_en/dout, full, empty.
module c2_ser_fifo
  import c2_pkg::*;
#(
  parameter int WIDTH = C2_CH*C2_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) begin
        dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = dout_q;

endmodule

// File: rtl/c2_serialize.sv
// c2_serialize: CH-lane conv2 words in, channel-interleaved DATA_W samples out (ch0..chCH-1 per word).
// Latency: word accepted at edge N into an idle block -> lane 0 valid after edge N+2; 1 beat/cycle sustained.
// Backpressure: data_in_ready = !fifo_full (low in reset); outputs hold while data_out_valid && !data_out_ready.
// Ports: clk, rst_n (async, active-high); data_in/_valid/_ready; data_out/_valid/_ready; frame_last, frame_done.
module c2_serialize
  import c2_pkg::*;
#(
  parameter int DATA_W     = C2_DATA_W,
  parameter int CH         = C2_CH,
  parameter int FRAME_LEN  = C2_FRAME_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH*DATA_W-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 frame_last,
  output logic                 frame_done
);

  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH-1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN-1);

  logic                 fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [CH*DATA_W-1:0] hold_word;
  logic [DATA_W-1:0]    lanes [CH];

  c2_state_e            state_q, state_d;
  logic [CH_W-1:0]      ch_cnt_q, ch_cnt_d, ch_nxt;
  logic [WC_W-1:0]      word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 pend_q, pend_d;
  logic                 frame_done_q, frame_done_d;
  logic                 lane_last, word_last, beat_acc, load, cur_done;

  assign fifo_wr = data_in_valid && data_in_ready;

  // The FIFO's registered read port doubles as the holding register: a word
  // popped into it stays there until its last lane has moved into data_out_q.
  c2_ser_fifo #(
    .WIDTH (CH*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (fifo_wr),
    .din   (data_in),
    .rd_en (fifo_rd),
    .dout  (hold_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar k = 0; k < CH; k++) begin : g_lane
    assign lanes[k] = hold_word[k*DATA_W +: DATA_W];
  end

  assign lane_last = (ch_cnt_q == CH_LAST);
  assign word_last = (word_cnt_q == WC_LAST);
  assign beat_acc  = (state_q == ST_SHIFT) && data_out_ready;
  assign ch_nxt    = ch_cnt_q + CH_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath next values. pend_q means the holding register
  // carries a popped word whose lane 0 has not been presented yet.
  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    data_out_d   = data_out_q;
    word_cnt_d   = word_cnt_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          load       = 1'b1;
          state_d    = ST_SHIFT;
          ch_cnt_d   = '0;
          data_out_d = lanes[0];
        end
      end
      ST_SHIFT: begin
        if (data_out_ready) begin
          if (!lane_last) begin
            ch_cnt_d   = ch_nxt;
            data_out_d = lanes[ch_nxt];
          end else begin
            word_cnt_d   = word_last ? '0 : word_cnt_q + WC_W'(1);
            frame_done_d = word_last;
            ch_cnt_d     = '0;
            if (pend_q) begin
              load       = 1'b1;
              data_out_d = lanes[0];
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop as soon as the holding register is no longer needed after this edge:
  // data_out_q will hold the final lane (or nothing) and no earlier pop is
  // still waiting. Popping while the last lane is on display is what lets the
  // next word follow with no bubble.
  assign cur_done = (state_d == ST_IDLE) || (ch_cnt_d == CH_LAST);
  assign fifo_rd  = !fifo_empty && !(pend_q && !load) && cur_done;
  assign pend_d   = (pend_q && !load) || fifo_rd;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ch_cnt_q     <= '0;
      word_cnt_q   <= '0;
      data_out_q   <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ch_cnt_q     <= ch_cnt_d;
      word_cnt_q   <= word_cnt_d;
      data_out_q   <= data_out_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs
  always_comb begin
    data_in_ready  = !fifo_full && !rst_n;
    data_out       = data_out_q;
    data_out_valid = (state_q == ST_SHIFT);
    frame_last     = (state_q == ST_SHIFT) && lane_last && word_last;
    frame_done     = frame_done_q;
  end

endmodule

// File: tb/tb_c2_serialize.sv
// tb_c2_serialize: directed-vector bench for c2_serialize with hand-computed expectations.
module tb_c2_serialize;
  import c2_pkg::*;

  localparam int DW = C2_DATA_W;
  localparam int CH = C2_CH;
  localparam int FL = C2_FRAME_LEN;
  localparam int WW = DW*CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [WW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
  logic          frame_last;
  logic          frame_done;

  always #5 clk = ~clk;

  c2_serialize #(
    .DATA_W     (DW),
    .CH         (CH),
    .FRAME_LEN  (FL),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_last     (frame_last),
    .frame_done     (frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit abort_push = 1'b0;

  int beats[$];
  int beat_cyc[$];
  int last_idx[$];
  int done_at[$];
  int done_cyc[$];

  always @(posedge clk) cyc++;

  // Log every beat that will be accepted on the coming edge, and frame_done pulses.
  always @(negedge clk) begin
    if (frame_done) begin
      done_at.push_back(beats.size());
      done_cyc.push_back(cyc);
    end
    if (data_out_valid && data_out_ready) begin
      if (frame_last) last_idx.push_back(beats.size());
      beats.push_back(int'(data_out));
      beat_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [WW-1:0] mk_word(input int b);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < CH; k++) begin
      int v;
      v = b + k;
      w[k*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  task automatic clear_log();
    beats.delete();
    beat_cyc.delete();
    last_idx.delete();
    done_at.delete();
    done_cyc.delete();
  endtask

  task automatic push_word(input logic [WW-1:0] w);
    int t;
    t = 0;
    data_in       = w;
    data_in_valid = 1'b1;
    @(negedge clk);
    while (!data_in_ready && !abort_push && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (abort_push) begin
      data_in_valid = 1'b0;
      return;
    end
    if (!data_in_ready) chk("push_timeout", {31'd0, data_in_ready}, 32'd1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic stream(input int nwords, input int base);
    for (int i = 0; i < nwords; i++) begin
      if (abort_push) break;
      push_word(mk_word(base + CH*i));
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t;
    t = 0;
    while (beats.size() < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  // Beat n must carry (base + n) mod 2^DW and there must be exactly n_exp beats.
  task automatic check_seq(input string tag, input int n_exp, input int base);
    int bad;
    bad = 0;
    chk({tag, "_cnt"}, beats.size(), n_exp);
    for (int n = 0; n < beats.size(); n++)
      if (beats[n] != ((base + n) & 16'hFFFF)) bad++;
    chk({tag, "_seq_errs"}, bad, 0);
  endtask

  initial begin
    logic [WW-1:0] w [6];
    int t;
    bit found;

    // Reset state (reset asserted from time 0)
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dat",  data_out, 0);
    chk("rst_vld",  data_out_valid, 0);
    chk("rst_last", frame_last, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_rdy",  data_in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", data_in_ready, 1);
    chk("idle_vld", data_out_valid, 0);

    // Full frame: 363 contiguous beats 0..362, one frame_last, one frame_done
    @(posedge clk);
    #1;
    data_out_ready = 1'b1;
    clear_log();
    stream(FL, 0);
    wait_beats(FL*CH, 400);
    check_seq("ff", FL*CH, 0);
    chk("ff_contig", qat(beat_cyc, FL*CH-1) - qat(beat_cyc, 0), FL*CH-1);
    chk("ff_last_n", last_idx.size(), 1);
    chk("ff_last_at", qat(last_idx, 0), FL*CH-1);
    chk("ff_done_n", done_at.size(), 1);
    chk("ff_done_at", qat(done_at, 0), FL*CH);
    chk("ff_done_dly", qat(done_cyc, 0) - qat(beat_cyc, FL*CH-1), 1);

    // Output backpressure: stall 5 cycles while lane 1 of word 7 (value 22) is shown
    @(posedge clk);
    #1;
    clear_log();
    fork
      stream(FL, 0);
      begin
        t = 0;
        found = 1'b0;
        while (t < 500 && !found) begin
          @(posedge clk);
          #1;
          if (data_out_valid && data_out == 16'd22) found = 1'b1;
          t++;
        end
        chk("bp_found", {31'd0, found}, 1);
        data_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_hold_dat", data_out, 22);
          chk("bp_hold_vld", data_out_valid, 1);
          @(posedge clk);
        end
        #1 data_out_ready = 1'b1;
      end
    join
    wait_beats(FL*CH, 400);
    check_seq("bp", FL*CH, 0);
    chk("bp_b22", qat(beats, 22), 22);
    chk("bp_b23", qat(beats, 23), 23);
    chk("bp_last_at", qat(last_idx, 0), FL*CH-1);

    // Two frames back to back
    @(posedge clk);
    #1;
    clear_log();
    stream(2*FL, 0);
    wait_beats(2*FL*CH, 800);
    check_seq("tf", 2*FL*CH, 0);
    chk("tf_last_n", last_idx.size(), 2);
    chk("tf_last_at0", qat(last_idx, 0), FL*CH-1);
    chk("tf_last_at1", qat(last_idx, 1), 2*FL*CH-1);
    chk("tf_done_n", done_at.size(), 2);
    chk("tf_done_at0", qat(done_at, 0), FL*CH);
    chk("tf_done_at1", qat(done_at, 1), 2*FL*CH);

    // Single word: lane 0 valid two edges after the accepting edge, then 1,2,3, then idle
    @(posedge clk);
    #1;
    clear_log();
    push_word(48'h0003_0002_0001);
    @(negedge clk);
    chk("sw_lat0_vld", data_out_valid, 0);
    @(negedge clk);
    chk("sw_lat1_vld", data_out_valid, 0);
    @(negedge clk);
    chk("sw_b0_vld", data_out_valid, 1);
    chk("sw_b0_dat", data_out, 16'h0001);
    @(negedge clk);
    chk("sw_b1_dat", data_out, 16'h0002);
    @(negedge clk);
    chk("sw_b2_dat", data_out, 16'h0003);
    @(negedge clk);
    chk("sw_end_vld", data_out_valid, 0);
    chk("sw_cnt", beats.size(), 3);

    // Input backpressure: 1 word held + 4 in FIFO, then the 6th waits upstream
    @(posedge clk);
    #1;
    data_out_ready = 1'b0;
    clear_log();
    for (int j = 0; j < 6; j++) w[j] = mk_word(256 + CH*j);
    for (int j = 0; j < 5; j++) push_word(w[j]);
    @(negedge clk);
    chk("ib_rdy_low", data_in_ready, 0);
    chk("ib_vld", data_out_valid, 1);
    chk("ib_dat", data_out, get_lane(w[0], 0));
    data_in       = w[5];
    data_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ib_hold_rdy", data_in_ready, 0);
    end
    @(posedge clk);
    #1 data_out_ready = 1'b1;
    push_word(w[5]);
    wait_beats(6*CH, 100);
    check_seq("ib", 6*CH, 256);

    // Reset mid-frame after beat 100, then a clean frame
    @(posedge clk);
    #1;
    clear_log();
    abort_push = 1'b0;
    fork
      stream(FL, 16'h2000);
      begin
        t = 0;
        while (beats.size() < 101 && t < 1000) begin
          @(negedge clk);
          #1;
          t++;
        end
        @(posedge clk);
        #2;
        rst_n      = 1'b1;
        abort_push = 1'b1;
        #1;
        chk("rm_dat",  data_out, 0);
        chk("rm_vld",  data_out_valid, 0);
        chk("rm_last", frame_last, 0);
        chk("rm_rdy",  data_in_ready, 0);
        chk("rm_nbeats", beats.size(), 101);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b0;
    abort_push = 1'b0;
    repeat (5) @(negedge clk);
    chk("rm_nostale", beats.size(), 101);
    chk("rm_idle_vld", data_out_valid, 0);
    @(posedge clk);
    #1;
    clear_log();
    stream(FL, 16'h3000);
    wait_beats(FL*CH, 400);
    check_seq("rn", FL*CH, 16'h3000);
    chk("rn_last_n", last_idx.size(), 1);
    chk("rn_last_at", qat(last_idx, 0), FL*CH-1);
    chk("rn_done_n", done_at.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
